// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants, FSM and requester encodings, size decoding
package mem_ctrl_pkg;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam int DATA_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  typedef enum logic [1:0] {FETCH, LOAD, STORE} req_e;
  function automatic logic [2:0] size_to_n(input logic [5:0] size);
    return size == 6'd1 ? 3'd1 : size == 6'd2 ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester ports (fetch, load, store) plus the byte-wide RAM port
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;
  logic                  in_rob_misbranch;
  logic                  in_fetch_ce;
  logic [DATA_WIDTH-1:0] in_fetch_addr;
  logic                  out_fetch_ce;
  logic [DATA_WIDTH-1:0] out_fetch_data;
  logic                  in_lsb_ce;
  logic [5:0]            in_lsb_size;
  logic                  in_lsb_signed;
  logic [DATA_WIDTH-1:0] in_lsb_addr;
  logic                  out_lsb_ce;
  logic [DATA_WIDTH-1:0] out_lsb_data;
  logic                  in_rob_ce;
  logic [5:0]            in_rob_size;
  logic [DATA_WIDTH-1:0] in_rob_addr;
  logic [DATA_WIDTH-1:0] in_rob_data;
  logic                  out_rob_ce;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [DATA_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;
  modport slave (
    input  in_rob_misbranch, in_fetch_ce, in_fetch_addr, in_lsb_ce, in_lsb_size, in_lsb_signed,
           in_lsb_addr, in_rob_ce, in_rob_size, in_rob_addr, in_rob_data, mem_din, io_buffer_full,
    output out_fetch_ce, out_fetch_data, out_lsb_ce, out_lsb_data, out_rob_ce, mem_dout, mem_a, mem_wr
  );
  modport master (
    output in_rob_misbranch, in_fetch_ce, in_fetch_addr, in_lsb_ce, in_lsb_size, in_lsb_signed,
           in_lsb_addr, in_rob_ce, in_rob_size, in_rob_addr, in_rob_data, mem_din, io_buffer_full,
    input  out_fetch_ce, out_fetch_data, out_lsb_ce, out_lsb_data, out_rob_ce, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller, store > load > fetch, little-endian assembly with extension
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rdy,
  mem_ctrl_if.slave bus
);
  state_e state_q, state_d;
  req_e req_q, req_d;
  logic pf_q, pf_d, pl_q, pl_d, ps_q, ps_d, lsg_q, lsg_d, sgn_q, sgn_d;
  logic [DATA_WIDTH-1:0] fa_q, fa_d, la_q, la_d, ra_q, ra_d, rd_q, rd_d;
  logic [5:0] ls_q, ls_d, rs_q, rs_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d, asm;
  logic [2:0] n_q, n_d, k_q, k_d;
  logic [DATA_WIDTH-1:0] mem_a_q, mem_a_d, fdata_q, fdata_d, ldata_q, ldata_d;
  logic [7:0] mem_dout_q, mem_dout_d;
  logic mem_wr_q, mem_wr_d, fce_q, fce_d, lce_q, lce_d, rce_q, rce_d;
  logic mb, idle, sel_s, sel_l, sel_f, stall_sel, stall;
  logic [1:0] bi;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] w, input logic [2:0] n, input logic s);
    return n == 3'd1 ? {{24{s & w[7]}}, w[7:0]} : n == 3'd2 ? {{16{s & w[15]}}, w[15:0]} : w;
  endfunction

  assign mb = bus.in_rob_misbranch;
  assign idle = state_q == IDLE || state_q == DONE;
  assign sel_s = idle & ps_q;
  assign sel_l = idle & !ps_q & pl_q & !mb;
  assign sel_f = idle & !ps_q & !pl_q & pf_q & !mb;
  // UART lives at addr[17:16] == 2'b11; mem_wr is registered so the stall takes effect next cycle
  assign stall_sel = ra_q[17:16] == 2'b11 && bus.io_buffer_full;
  assign stall = addr_q[17:16] == 2'b11 && bus.io_buffer_full;
  assign bi = k_q[1:0] - 2'd1;

  always_comb begin
    asm = buf_q;
    asm[{bi, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    state_d = state_q;
    req_d = req_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    buf_d = buf_q;
    n_d = n_q;
    k_d = k_q;
    sgn_d = sgn_q;
    mem_a_d = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d = FALSE;
    fce_d = FALSE;
    lce_d = FALSE;
    rce_d = FALSE;
    fdata_d = fdata_q;
    ldata_d = ldata_q;
    pf_d = (bus.in_fetch_ce | pf_q & !sel_f) & !mb;
    pl_d = (bus.in_lsb_ce | pl_q & !sel_l) & !mb;
    ps_d = bus.in_rob_ce | ps_q & !sel_s;
    fa_d = bus.in_fetch_ce ? bus.in_fetch_addr : fa_q;
    la_d = bus.in_lsb_ce ? bus.in_lsb_addr : la_q;
    ls_d = bus.in_lsb_ce ? bus.in_lsb_size : ls_q;
    lsg_d = bus.in_lsb_ce ? bus.in_lsb_signed : lsg_q;
    ra_d = bus.in_rob_ce ? bus.in_rob_addr : ra_q;
    rd_d = bus.in_rob_ce ? bus.in_rob_data : rd_q;
    rs_d = bus.in_rob_ce ? bus.in_rob_size : rs_q;
    if (idle) begin
      state_d = IDLE;
      if (sel_s) begin
        state_d = WRITE;
        req_d = STORE;
        addr_d = ra_q;
        wdata_d = rd_q;
        n_d = size_to_n(rs_q);
        k_d = 3'd0;
        mem_a_d = ra_q;
        mem_dout_d = rd_q[7:0];
        mem_wr_d = !stall_sel;
      end else if (sel_l | sel_f) begin
        state_d = READ;
        req_d = sel_l ? LOAD : FETCH;
        addr_d = sel_l ? la_q : fa_q;
        n_d = sel_l ? size_to_n(ls_q) : 3'd4;
        sgn_d = sel_l & lsg_q;
        k_d = 3'd0;
        mem_a_d = addr_d;
      end
    end else if (state_q == READ) begin
      // byte k-1 arrives on mem_din while address k is on mem_a
      if (mb) state_d = IDLE;
      else begin
        k_d = k_q + 3'd1;
        mem_a_d = addr_q + {29'd0, k_q} + 32'd1;
        buf_d = k_q == 3'd0 ? buf_q : asm;
        if (k_q == n_q) begin
          state_d = DONE;
          fce_d = req_q == FETCH;
          lce_d = req_q == LOAD;
          fdata_d = req_q == FETCH ? asm : fdata_q;
          ldata_d = req_q == LOAD ? extend(asm, n_q, sgn_q) : ldata_q;
        end
      end
    end else begin
      mem_wr_d = !stall;
      if (mem_wr_q && k_q == n_q - 3'd1) begin
        state_d = DONE;
        rce_d = TRUE;
        mem_wr_d = FALSE;
      end else if (mem_wr_q) begin
        k_d = k_q + 3'd1;
        mem_a_d = addr_q + {29'd0, k_d};
        mem_dout_d = wdata_q[{k_d[1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q <= FETCH;
      {pf_q, pl_q, ps_q, lsg_q, sgn_q} <= '0;
      {fa_q, la_q, ra_q, rd_q, ls_q, rs_q} <= '0;
      {addr_q, wdata_q, buf_q, n_q, k_q} <= '0;
      {mem_a_q, mem_dout_q, mem_wr_q} <= '0;
      {fce_q, lce_q, rce_q, fdata_q, ldata_q} <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      req_q <= req_d;
      {pf_q, pl_q, ps_q, lsg_q, sgn_q} <= {pf_d, pl_d, ps_d, lsg_d, sgn_d};
      {fa_q, la_q, ra_q, rd_q, ls_q, rs_q} <= {fa_d, la_d, ra_d, rd_d, ls_d, rs_d};
      {addr_q, wdata_q, buf_q, n_q, k_q} <= {addr_d, wdata_d, buf_d, n_d, k_d};
      {mem_a_q, mem_dout_q, mem_wr_q} <= {mem_a_d, mem_dout_d, mem_wr_d};
      {fce_q, lce_q, rce_q, fdata_q, ldata_q} <= {fce_d, lce_d, rce_d, fdata_d, ldata_d};
    end
  end

  assign bus.mem_a = mem_a_q;
  assign bus.mem_dout = mem_dout_q;
  assign bus.mem_wr = mem_wr_q;
  assign bus.out_fetch_ce = fce_q;
  assign bus.out_fetch_data = fdata_q;
  assign bus.out_lsb_ce = lce_q;
  assign bus.out_lsb_data = ldata_q;
  assign bus.out_rob_ce = rce_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven and scoreboarded checks of mem_ctrl against a byte RAM model
module tb_mem_ctrl;
  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int pulses [3] = '{0, 0, 0};
  int last_cyc [3] = '{0, 0, 0};
  logic [7:0] ram [0:262143];

  typedef struct { string name; int port; logic [31:0] data; int due; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int c; } wr_t;
  typedef struct { string name; int op; logic [31:0] addr; logic [5:0] size; logic sgn; logic [31:0] wdata; logic [31:0] exp; } vec_t;
  exp_t sb [$];
  wr_t wlog [$];
  vec_t vt [17];

  mem_ctrl_if bus();
  mem_ctrl dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rdy) begin
    if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
    bus.mem_din <= ram[bus.mem_a[17:0]];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic got(input int p, input logic [31:0] d);
    exp_t e;
    pulses[p]++;
    last_cyc[p] = cyc;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_pulse: port %0d pulsed at cycle %0d, expected none", p, cyc);
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s_port", e.name), p, e.port);
      if (p != 2) chk($sformatf("%s_data", e.name), d, e.data);
      if (e.due >= 0) chk($sformatf("%s_cycle", e.name), cyc, e.due);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.mem_wr) wlog.push_back('{bus.mem_a, bus.mem_dout, cyc});
    if (bus.out_fetch_ce) got(0, bus.out_fetch_data);
    if (bus.out_lsb_ce) got(1, bus.out_lsb_data);
    if (bus.out_rob_ce) got(2, 32'h0);
  end

  function automatic int bn(input logic [5:0] s);
    return s == 6'd1 ? 1 : s == 6'd2 ? 2 : 4;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
    bus.in_fetch_ce = 1'b0;
    bus.in_lsb_ce = 1'b0;
    bus.in_rob_ce = 1'b0;
    bus.in_rob_misbranch = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic issue(input int op, input logic [31:0] a, input logic [5:0] sz, input logic sg, input logic [31:0] wd);
    if (op == 0) begin bus.in_fetch_ce = 1'b1; bus.in_fetch_addr = a; end
    if (op == 1) begin bus.in_lsb_ce = 1'b1; bus.in_lsb_addr = a; bus.in_lsb_size = sz; bus.in_lsb_signed = sg; end
    if (op == 2) begin bus.in_rob_ce = 1'b1; bus.in_rob_addr = a; bus.in_rob_size = sz; bus.in_rob_data = wd; end
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 80) begin tick(); t++; end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", nm, sb.size());
      sb.delete();
    end
    tick();
  endtask

  task automatic check_writes(input string nm, input int t, input logic [31:0] a, input logic [31:0] d, input int n);
    chk($sformatf("%s_wr_count", nm), wlog.size(), n);
    for (int k = 0; k < n && k < wlog.size(); k++) begin
      chk($sformatf("%s_wr%0d_addr", nm, k), wlog[k].a, a + k);
      chk($sformatf("%s_wr%0d_data", nm, k), {24'h0, wlog[k].d}, {24'h0, d[8*k +: 8]});
      if (t >= 0) chk($sformatf("%s_wr%0d_cycle", nm, k), wlog[k].c, t + 2 + k);
    end
  endtask

  initial begin
    int t, n, p0, p1, p2;
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, n, p0, p1, p2;
    for (int i = 0; i < 262144; i++) ram[i] <= 8'h00;
    #1;
    ram[18'h100] <= 8'h13; ram[18'h101] <= 8'h05; ram[18'h102] <= 8'h10; ram[18'h103] <= 8'h00;
    ram[18'h200] <= 8'hF0; ram[18'h201] <= 8'h80; ram[18'h202] <= 8'h34; ram[18'h203] <= 8'h92;
    ram[18'h3FFFF] <= 8'h11; ram[18'h0] <= 8'h22; ram[18'h1] <= 8'h33; ram[18'h2] <= 8'h44;
    {bus.in_fetch_ce, bus.in_lsb_ce, bus.in_rob_ce, bus.in_rob_misbranch, bus.io_buffer_full} = '0;
    {bus.in_fetch_addr, bus.in_lsb_addr, bus.in_rob_addr, bus.in_rob_data} = '0;
    {bus.in_lsb_size, bus.in_rob_size, bus.in_lsb_signed} = '0;
    vt[0]  = '{"fetch",      0, 32'h100,      6'd4, 1'b0, 32'h0,        32'h00100513};
    vt[1]  = '{"fetch_wrap", 0, 32'hFFFFFFFF, 6'd4, 1'b0, 32'h0,        32'h44332211};
    vt[2]  = '{"lb",         1, 32'h200,      6'd1, 1'b1, 32'h0,        32'hFFFFFFF0};
    vt[3]  = '{"lbu",        1, 32'h200,      6'd1, 1'b0, 32'h0,        32'h000000F0};
    vt[4]  = '{"lh",         1, 32'h200,      6'd2, 1'b1, 32'h0,        32'hFFFF80F0};
    vt[5]  = '{"lhu",        1, 32'h200,      6'd2, 1'b0, 32'h0,        32'h000080F0};
    vt[6]  = '{"lb_201",     1, 32'h201,      6'd1, 1'b1, 32'h0,        32'hFFFFFF80};
    vt[7]  = '{"lh_202",     1, 32'h202,      6'd2, 1'b1, 32'h0,        32'hFFFF9234};
    vt[8]  = '{"lw_signed",  1, 32'h200,      6'd4, 1'b1, 32'h0,        32'h923480F0};
    vt[9]  = '{"size3_as4",  1, 32'h200,      6'd3, 1'b1, 32'h0,        32'h923480F0};
    vt[10] = '{"sw",         2, 32'h300,      6'd4, 1'b0, 32'hDEADBEEF, 32'h0};
    vt[11] = '{"lw_300",     1, 32'h300,      6'd4, 1'b0, 32'h0,        32'hDEADBEEF};
    vt[12] = '{"sb",         2, 32'h310,      6'd1, 1'b0, 32'h000055AA, 32'h0};
    vt[13] = '{"lw_310",     1, 32'h310,      6'd4, 1'b0, 32'h0,        32'h000000AA};
    vt[14] = '{"sh",         2, 32'h320,      6'd2, 1'b0, 32'h12348001, 32'h0};
    vt[15] = '{"lh_320",     1, 32'h320,      6'd2, 1'b1, 32'h0,        32'hFFFF8001};
    vt[16] = '{"lhu_321",    1, 32'h321,      6'd2, 1'b0, 32'h0,        32'h00000080};
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_dout", {24'h0, bus.mem_dout}, 32'h0);
    chk("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    chk("rst_ces", {29'h0, bus.out_fetch_ce, bus.out_lsb_ce, bus.out_rob_ce}, 32'h0);
    chk("rst_fetch_data", bus.out_fetch_data, 32'h0);
    chk("rst_lsb_data", bus.out_lsb_data, 32'h0);

    for (int i = 0; i < 17; i++) begin
      t = cyc;
      n = vt[i].op == 0 ? 4 : bn(vt[i].size);
      wlog.delete();
      issue(vt[i].op, vt[i].addr, vt[i].size, vt[i].sgn, vt[i].wdata);
      sb.push_back('{vt[i].name, vt[i].op, vt[i].exp, vt[i].op == 2 ? t + n + 2 : t + n + 3});
      tick();
      drain(vt[i].name);
      if (vt[i].op == 2) check_writes(vt[i].name, t, vt[i].addr, vt[i].wdata, n);
    end
    chk("data_hold_fetch", bus.out_fetch_data, 32'h44332211);

    // all three requesters in one cycle
    t = cyc; p0 = pulses[0]; p1 = pulses[1]; p2 = pulses[2];
    issue(0, 32'h100, 6'd4, 1'b0, 32'h0);
    issue(1, 32'h200, 6'd1, 1'b1, 32'h0);
    issue(2, 32'h340, 6'd4, 1'b0, 32'h11223344);
    sb.push_back('{"prio_store", 2, 32'h0, t + 6});
    sb.push_back('{"prio_load", 1, 32'hFFFFFFF0, t + 9});
    sb.push_back('{"prio_fetch", 0, 32'h00100513, t + 15});
    tick();
    drain("prio");
    repeat (5) tick();
    chk("prio_one_fetch", pulses[0] - p0, 1);
    chk("prio_one_load", pulses[1] - p1, 1);
    chk("prio_one_store", pulses[2] - p2, 1);

    // misbranch two cycles into a word load
    t = cyc; p1 = pulses[1];
    issue(1, 32'h200, 6'd4, 1'b0, 32'h0);
    tick();
    wait_cyc(t + 3);
    bus.in_rob_misbranch = 1'b1;
    repeat (12) tick();
    chk("mb_load_no_pulse", pulses[1] - p1, 0);
    t = cyc;
    issue(0, 32'h100, 6'd4, 1'b0, 32'h0);
    sb.push_back('{"mb_after_fetch", 0, 32'h00100513, t + 7});
    tick();
    drain("mb_after_fetch");

    // misbranch with simultaneous load and store pulses: load dropped, store kept
    t = cyc; p1 = pulses[1]; wlog.delete();
    issue(1, 32'h200, 6'd1, 1'b0, 32'h0);
    issue(2, 32'h3A0, 6'd1, 1'b0, 32'h00000077);
    bus.in_rob_misbranch = 1'b1;
    sb.push_back('{"mb_same_store", 2, 32'h0, t + 3});
    tick();
    drain("mb_same_store");
    repeat (10) tick();
    chk("mb_same_load_dropped", pulses[1] - p1, 0);
    check_writes("mb_same_store", t, 32'h3A0, 32'h77, 1);

    // misbranch during a word store
    t = cyc; wlog.delete();
    issue(2, 32'h380, 6'd4, 1'b0, 32'hCAFEF00D);
    sb.push_back('{"mb_store", 2, 32'h0, t + 6});
    tick();
    wait_cyc(t + 3);
    bus.in_rob_misbranch = 1'b1;
    drain("mb_store");
    check_writes("mb_store", t, 32'h380, 32'hCAFEF00D, 4);
    t = cyc;
    issue(1, 32'h380, 6'd4, 1'b0, 32'h0);
    sb.push_back('{"mb_store_readback", 1, 32'hCAFEF00D, t + 7});
    tick();
    drain("mb_store_readback");

    // UART store stalled for 5 cycles by io_buffer_full
    t = cyc; wlog.delete();
    bus.io_buffer_full = 1'b1;
    issue(2, 32'h30000, 6'd1, 1'b0, 32'h000000A5);
    sb.push_back('{"uart_store", 2, 32'h0, -1});
    tick();
    wait_cyc(t + 5);
    bus.io_buffer_full = 1'b0;
    drain("uart_store");
    check_writes("uart", -1, 32'h30000, 32'hA5, 1);
    if (wlog.size() == 1) begin
      chk("uart_no_write_while_full", {31'h0, wlog[0].c > t + 4}, 32'h1);
      chk("uart_pulse_after_write", last_cyc[2], wlog[0].c + 1);
    end

    // io_buffer_full does not stall a non-UART address
    t = cyc; wlog.delete();
    bus.io_buffer_full = 1'b1;
    issue(2, 32'h390, 6'd1, 1'b0, 32'h0000003C);
    sb.push_back('{"nonuart_store", 2, 32'h0, t + 3});
    tick();
    drain("nonuart_store");
    bus.io_buffer_full = 1'b0;
    check_writes("nonuart", t, 32'h390, 32'h3C, 1);

    // rdy low for 3 cycles mid-fetch delays the pulse by 3
    t = cyc;
    issue(0, 32'h100, 6'd4, 1'b0, 32'h0);
    sb.push_back('{"rdy_fetch", 0, 32'h00100513, t + 10});
    tick();
    wait_cyc(t + 3);
    rdy = 1'b0;
    wait_cyc(t + 6);
    rdy = 1'b1;
    drain("rdy_fetch");

    // reset mid-load aborts with no pulse and clears outputs
    t = cyc; p1 = pulses[1];
    issue(1, 32'h200, 6'd4, 1'b0, 32'h0);
    tick();
    wait_cyc(t + 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_mid_no_pulse", pulses[1] - p1, 0);
    chk("rst_mid_lsb_data", bus.out_lsb_data, 32'h0);
    chk("rst_mid_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    t = cyc;
    issue(1, 32'h300, 6'd2, 1'b1, 32'h0);
    sb.push_back('{"rst_after_load", 1, 32'hFFFFBEEF, t + 5});
    tick();
    drain("rst_after_load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
